pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised elastic pipeline stage register replacing fixed stage latches (e.g. MEM->WB).
//  2-entry skid buffer (main + skid) with valid/ready handshake, synchronous flush and
//  registered in_ready, so stalls propagate one stage per cycle without combinational paths.
//  Carries payload, destination register and write-enable; optional Tnew countdown for hazard logic.
// PARAMETERS
//  DATA_W   32  payload width (PC, PC8, ALU result, mem data, ctrl concatenated by instantiator)
//  DST_W    5   destination register index width
//  TNEW_W   2   Tnew field width (used only with PIPE_TNEW_EN)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  flush         in   1       discard all held entries at next edge
//  in_valid      in   1       upstream entry present
//  in_ready      out  1       stage can accept (function of state only)
//  in_data       in   DATA_W  payload
//  in_dst        in   DST_W   destination register
//  in_regwrite   in   1       entry writes register file
//  in_tnew       in   TNEW_W  cycles until result ready
//  out_valid     out  1       main entry valid
//  out_ready     in   1       downstream accepts
//  out_data      out  DATA_W  main payload
//  out_dst       out  DST_W   main destination
//  out_regwrite  out  1       main_regwrite & out_valid (never asserted on a bubble)
//  out_tnew      out  TNEW_W  main Tnew
//  occupancy     out  2       entries held: 0,1,2
// BEHAVIOUR
//  - Reset (reset_n low, async): state EMPTY; all stored fields 0; out_* 0; occupancy 0; in_ready 0 while low, 1 after.
//  - accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
//  - in_ready = (state != FULL); out_valid = (state != EMPTY). Latency EMPTY->out_valid: 1 cycle.
//  - States/transitions (flush absent):
//    EMPTY: accept -> ONE, main<=in.
//    ONE:   accept&pop -> ONE, main<=in; accept&~pop -> FULL, skid<=in; pop only -> EMPTY; else hold.
//    FULL:  pop -> ONE, main<=skid; else hold (no accept possible).
//  - flush: highest priority; next state EMPTY from any state, in-flight input dropped, valid bits
//    cleared; payload fields need not clear. A pop coinciding with flush counts as consumed downstream.
//  - Order preserved: skid entry is always older than any new input; no entry duplicated or lost.
//  - Held fields stable while out_valid & ~out_ready (checked by assertion).
//  - Reset mid-operation: all entries lost immediately, no partial transfer.
// CONFIGURATION
//  - PIPE_TNEW_EN defined: each entry stores tnew; on capture tnew<=in_tnew; every edge while valid
//    and not overwritten tnew<=tnew-(tnew!=0) (saturate at 0); skid->main move carries decremented value.
//  - PIPE_TNEW_EN undefined: no tnew storage; out_tnew tied to 0; in_tnew ignored.
// STRUCTURE
//  - Shared package pipe_pkg: typedef enum state_t {EMPTY, ONE, FULL}; default TNEW_W constant.
//  - Sub-module pipe_entry_reg: one storage entry (valid, data, dst, regwrite, tnew with saturating
//    decrement); instantiated twice (main, skid). Control FSM in top.
// TESTING
//  1 Reset: reset_n low mid-stream with FULL -> same cycle occupancy 0, out_valid 0; release -> in_ready 1.
//  2 Streaming: in_valid=1, out_ready=1, data 1..8 -> out_data 1..8 one cycle late, occupancy stays 1.
//  3 Back-pressure: out_ready=0, send A,B -> occupancy 2, in_ready 0; out_ready=1 -> A then B, in_ready 1.
//  4 Flush: FULL with A,B, flush=1 & in_valid=1 data C -> next cycle EMPTY, C never appears at output.
//  5 Bubble: in_valid=0, in_regwrite=1 -> out_regwrite stays 0; dst=5 regwrite=1 entry -> out_regwrite 1.
//  6 PIPE_TNEW_EN: in_tnew=2, out_ready=0 for 4 cycles -> out_tnew 2,1,0,0; undefined build -> 0 always.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage buffer (pipe_stage_buf).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int DST_W_DEF  = 5;
  localparam int TNEW_W_DEF = 2;

  // Number of held entries from the two valid bits.
  function automatic logic [1:0] entry_count(input logic main_valid, input logic skid_valid);
    return {main_valid & skid_valid, main_valid ^ skid_valid};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage entry of the stage buffer: valid, payload, destination, regwrite and, when
// PIPE_TNEW_EN is defined, a Tnew field that counts down to 0 every cycle it is held.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DST_W  = DST_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_load_dec,
  input  logic              i_drop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DST_W-1:0]  i_dst,
  input  logic              i_regwrite,
  input  logic [TNEW_W-1:0] i_tnew,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [DST_W-1:0]  o_dst,
  output logic              o_regwrite,
  output logic [TNEW_W-1:0] o_tnew
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [DST_W-1:0]  r_dst;
  logic              r_regwrite;

  // NOTE: payload fields are reset along with valid so every output reads 0 out of reset;
  // state updates use <= so all entries sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_dst      <= '0;
      r_regwrite <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_data     <= i_data;
      r_dst      <= i_dst;
      r_regwrite <= i_regwrite;
    end else if (i_drop) begin
      r_valid    <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_dst      = r_dst;
  assign o_regwrite = r_regwrite;

`ifdef PIPE_TNEW_EN
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] value);
    return (value != '0) ? value - TNEW_W'(1) : value;
  endfunction

  logic [TNEW_W-1:0] r_tnew;
  logic [TNEW_W-1:0] w_load_tnew;

  // A value moved in from the skid entry has also aged by this edge.
  assign w_load_tnew = i_load_dec ? sat_dec(i_tnew) : i_tnew;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tnew <= '0;
    end else if (i_load) begin
      r_tnew <= w_load_tnew;
    end else if (r_valid) begin
      r_tnew <= sat_dec(r_tnew);
    end
  end

  assign o_tnew = r_tnew;
`else
  logic w_unused_tnew;
  assign w_unused_tnew = ^{i_tnew, i_load_dec};
  assign o_tnew        = '0;
`endif

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic 2-entry (main + skid) pipeline stage with registered in_ready and synchronous flush.
// Optional Tnew countdown per entry is enabled with the PIPE_TNEW_EN macro.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DST_W  = DST_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DST_W-1:0]  in_dst,
  input  logic              in_regwrite,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DST_W-1:0]  out_dst,
  output logic              out_regwrite,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [1:0]        occupancy
);

  state_t r_state;
  state_t w_state_next;
  logic   r_in_ready;

  logic w_accept;
  logic w_pop;
  logic w_main_load;
  logic w_main_from_skid;
  logic w_main_drop;
  logic w_skid_load;
  logic w_skid_drop;

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [DST_W-1:0]  w_main_dst;
  logic              w_main_regwrite;
  logic [TNEW_W-1:0] w_main_tnew;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [DST_W-1:0]  w_skid_dst;
  logic              w_skid_regwrite;
  logic [TNEW_W-1:0] w_skid_tnew;

  logic [DATA_W-1:0] w_main_in_data;
  logic [DST_W-1:0]  w_main_in_dst;
  logic              w_main_in_regwrite;
  logic [TNEW_W-1:0] w_main_in_tnew;

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_pop    = w_main_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != FULL);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned.
  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_drop      = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_drop      = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
      w_main_drop  = 1'b1;
      w_skid_drop  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_next = ONE;
            w_main_load  = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_main_load  = 1'b1;
          end else if (w_accept) begin
            w_state_next = FULL;
            w_skid_load  = 1'b1;
          end else if (w_pop) begin
            w_state_next = EMPTY;
            w_main_drop  = 1'b1;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_next     = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_drop      = 1'b1;
          end
        end
        default: begin
          w_state_next = EMPTY;
          w_main_drop  = 1'b1;
          w_skid_drop  = 1'b1;
        end
      endcase
    end
  end

  assign w_main_in_data     = w_main_from_skid ? w_skid_data     : in_data;
  assign w_main_in_dst      = w_main_from_skid ? w_skid_dst      : in_dst;
  assign w_main_in_regwrite = w_main_from_skid ? w_skid_regwrite : in_regwrite;
  assign w_main_in_tnew     = w_main_from_skid ? w_skid_tnew     : in_tnew;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .DST_W  (DST_W),
    .TNEW_W (TNEW_W)
  ) u_main (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_main_load),
    .i_load_dec (w_main_from_skid),
    .i_drop     (w_main_drop),
    .i_data     (w_main_in_data),
    .i_dst      (w_main_in_dst),
    .i_regwrite (w_main_in_regwrite),
    .i_tnew     (w_main_in_tnew),
    .o_valid    (w_main_valid),
    .o_data     (w_main_data),
    .o_dst      (w_main_dst),
    .o_regwrite (w_main_regwrite),
    .o_tnew     (w_main_tnew)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .DST_W  (DST_W),
    .TNEW_W (TNEW_W)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_skid_load),
    .i_load_dec (1'b0),
    .i_drop     (w_skid_drop),
    .i_data     (in_data),
    .i_dst      (in_dst),
    .i_regwrite (in_regwrite),
    .i_tnew     (in_tnew),
    .o_valid    (w_skid_valid),
    .o_data     (w_skid_data),
    .o_dst      (w_skid_dst),
    .o_regwrite (w_skid_regwrite),
    .o_tnew     (w_skid_tnew)
  );

  assign in_ready     = r_in_ready;
  assign out_valid    = w_main_valid;
  assign out_data     = w_main_data;
  assign out_dst      = w_main_dst;
  assign out_regwrite = w_main_regwrite & w_main_valid;
  assign out_tnew     = w_main_tnew;
  assign occupancy    = entry_count(w_main_valid, w_skid_valid);

  // A stalled entry must not change under the consumer (Tnew is allowed to age).
  a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready && !flush) |=>
      ($stable(out_data) && $stable(out_dst) && $stable(out_regwrite)));

  a_state_match: assert property (@(posedge clk) disable iff (!reset_n)
    (w_main_valid == (r_state != EMPTY)) && (w_skid_valid == (r_state == FULL)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus randomized traffic against a
// queue-based reference model. Tnew expectations follow the PIPE_TNEW_EN macro.
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int DST_W  = 5;
  localparam int TNEW_W = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DST_W-1:0]  in_dst;
  logic              in_regwrite;
  logic [TNEW_W-1:0] in_tnew;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DST_W-1:0]  out_dst;
  logic              out_regwrite;
  logic [TNEW_W-1:0] out_tnew;
  logic [1:0]        occupancy;

  pipe_stage_buf #(.DATA_W(DATA_W), .DST_W(DST_W), .TNEW_W(TNEW_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_dst       (in_dst),
    .in_regwrite  (in_regwrite),
    .in_tnew      (in_tnew),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dst      (out_dst),
    .out_regwrite (out_regwrite),
    .out_tnew     (out_tnew),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DST_W-1:0]  dst;
    logic              rw;
    int                tnew;
  } ent_t;

  ent_t mq[$];
  bit   rdy;
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic bit tnew_on();
`ifdef PIPE_TNEW_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ready();
    return rdy && (mq.size() < 2);
  endfunction

  function automatic logic [TNEW_W-1:0] exp_tnew();
    if (!tnew_on() || mq.size() == 0) return '0;
    return TNEW_W'(mq[0].tnew);
  endfunction

  // Drive one cycle's inputs (called at a negedge), advance the model across the next
  // rising edge, and return at the following negedge with outputs settled.
  task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic [DST_W-1:0] ds,
                      input logic rw, input logic [TNEW_W-1:0] tn, input logic ordy, input logic fl);
    bit   acc;
    bit   pp;
    ent_t e;
    in_valid = v; in_data = d; in_dst = ds; in_regwrite = rw; in_tnew = tn;
    out_ready = ordy; flush = fl;
    acc = v && exp_ready() && !fl;
    pp  = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      foreach (mq[i]) mq[i].tnew = (mq[i].tnew > 0) ? mq[i].tnew - 1 : 0;
      if (acc) begin
        e.data = d; e.dst = ds; e.rw = rw; e.tnew = int'(tn);
        mq.push_back(e);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, 1'b0, '0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; flush = 0; in_valid = 0; in_data = '0; in_dst = '0;
    in_regwrite = 0; in_tnew = '0; out_ready = 0;
    #1 reset_n = 1'b0;
    mq.delete(); rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (occupancy !== 2'd0) begin n_fails++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_data !== '0) begin n_fails++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_checks++; if (out_regwrite !== 1'b0 || out_tnew !== '0 || out_dst !== '0) begin
      n_fails++; $display("FAIL rst_fields: got rw=%b tnew=%0d dst=%0d want 0", out_regwrite, out_tnew, out_dst);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    // Fill to FULL, then pull reset low between edges.
    tick(1'b1, 32'hA0A0_0001, 5'd1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 32'hB0B0_0002, 5'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2) begin n_fails++; $display("FAIL rst_fill_occ: got %0d want 2", occupancy); end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    mq.delete(); rdy = 1'b0;
    #1;
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid: got occ=%0d valid=%b want occ=0 valid=0", occupancy, out_valid);
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b1);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, DATA_W'(k), 5'd3, 1'b1, 2'd0, 1'b1, 1'b0);
      n_checks++; if (out_data !== DATA_W'(k) || out_valid !== 1'b1) begin
        n_fails++; $display("FAIL stream_data[%0d]: got %0d valid=%b want %0d valid=1", k, out_data, out_valid, k);
      end
      n_checks++; if (occupancy !== 2'd1) begin n_fails++; $display("FAIL stream_occ[%0d]: got %0d want 1", k, occupancy); end
    end
    idle(1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    tick(1'b1, 32'h0000_00AA, 5'd4, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 32'h0000_00BB, 5'd6, 1'b1, 2'd0, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fails++; $display("FAIL bp_full: got occ=%0d ready=%b want occ=2 ready=0", occupancy, in_ready);
    end
    n_checks++; if (out_data !== 32'h0000_00AA) begin n_fails++; $display("FAIL bp_first: got %h want aa", out_data); end
    idle(1'b1);
    n_checks++; if (out_data !== 32'h0000_00BB || out_dst !== 5'd6 || in_ready !== 1'b1) begin
      n_fails++; $display("FAIL bp_second: got %h dst=%0d ready=%b want bb dst=6 ready=1", out_data, out_dst, in_ready);
    end
    idle(1'b1);
    n_checks++; if (occupancy !== 2'd0) begin n_fails++; $display("FAIL bp_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    tick(1'b1, 32'h0000_000A, 5'd1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 32'h0000_000B, 5'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 32'h0000_000C, 5'd3, 1'b1, 2'd0, 1'b0, 1'b1);
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++; $display("FAIL flush_empty: got occ=%0d valid=%b ready=%b want 0 0 1", occupancy, out_valid, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      n_checks++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0) begin
        n_fails++; $display("FAIL flush_no_c[%0d]: got valid=%b data=%h want valid=0", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_bubble();
    tick(1'b0, 32'h1234_5678, 5'd7, 1'b1, 2'd0, 1'b1, 1'b0);
    n_checks++; if (out_regwrite !== 1'b0) begin n_fails++; $display("FAIL bubble_rw: got %b want 0", out_regwrite); end
    tick(1'b1, 32'h0000_0055, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0);
    n_checks++; if (out_regwrite !== 1'b1 || out_dst !== 5'd5) begin
      n_fails++; $display("FAIL bubble_entry: got rw=%b dst=%0d want rw=1 dst=5", out_regwrite, out_dst);
    end
    tick(1'b0, '0, 5'd9, 1'b1, 2'd0, 1'b1, 1'b0);
    n_checks++; if (out_regwrite !== 1'b0) begin n_fails++; $display("FAIL bubble_after_pop: got %b want 0", out_regwrite); end
    tick(1'b1, 32'h0000_0066, 5'd8, 1'b0, 2'd0, 1'b1, 1'b0);
    n_checks++; if (out_regwrite !== 1'b0 || out_valid !== 1'b1) begin
      n_fails++; $display("FAIL bubble_norw: got rw=%b valid=%b want rw=0 valid=1", out_regwrite, out_valid);
    end
    idle(1'b1);
  endtask

  task automatic test_tnew();
    logic [TNEW_W-1:0] want [4];
    want[0] = tnew_on() ? 2'd2 : 2'd0;
    want[1] = tnew_on() ? 2'd1 : 2'd0;
    want[2] = 2'd0;
    want[3] = 2'd0;
    tick(1'b1, 32'h0000_0077, 5'd10, 1'b1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_tnew !== want[k]) begin
        n_fails++; $display("FAIL tnew[%0d]: got %0d want %0d", k, out_tnew, want[k]);
      end
      if (k < 3) idle(1'b0);
    end
    idle(1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick(($urandom % 4) != 0, DATA_W'($urandom), DST_W'($urandom), 1'($urandom),
           TNEW_W'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
      n_checks++; if (in_ready !== exp_ready()) begin
        n_fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, in_ready, exp_ready());
      end
      n_checks++; if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() != 0)) begin
        n_fails++; $display("FAIL rnd_occ[%0d]: got occ=%0d valid=%b want occ=%0d", n, occupancy, out_valid, mq.size());
      end
      if (mq.size() != 0) begin
        n_checks++; if (out_data !== mq[0].data || out_dst !== mq[0].dst || out_regwrite !== mq[0].rw) begin
          n_fails++; $display("FAIL rnd_entry[%0d]: got %h/%0d/%b want %h/%0d/%b", n,
                              out_data, out_dst, out_regwrite, mq[0].data, mq[0].dst, mq[0].rw);
        end
        n_checks++; if (out_tnew !== exp_tnew()) begin
          n_fails++; $display("FAIL rnd_tnew[%0d]: got %0d want %0d", n, out_tnew, exp_tnew());
        end
      end else begin
        n_checks++; if (out_regwrite !== 1'b0) begin
          n_fails++; $display("FAIL rnd_bubble_rw[%0d]: got %b want 0", n, out_regwrite);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble();
    test_tnew();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
